idelay_load_seq: RTL and testbench
==================================

IDELAY_LOAD_SEQ -- requirements
Module: idelay_load_seq

Interface
REQ-001 Parameter NUM_LANES, default 8: number of delay lanes sequenced (1..32).
REQ-002 Parameter LANE_W, default 3: width of the lane index (ceil log2 NUM_LANES, minimum 1).
REQ-003 Parameter SETTLE, default 2: idle cycles inserted between the last pipeline load and the set pulse (0..15).
REQ-004 Parameter DELAY_VALUE, default 0: reset value of all shadow delay registers (0..31).
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  block can accept a command this cycle.
REQ-009 cmd_apply  input  1  0 = load lane pipeline register; 1 = apply all pending loads.
REQ-010 cmd_lane  input  LANE_W  target lane (ignored when cmd_apply=1).
REQ-011 cmd_delay  input  5  tap value (ignored when cmd_apply=1).
REQ-012 dly_data  output  5  shared tap bus to every lane's counter-value input.
REQ-013 dly_ld  output  NUM_LANES  per-lane pipeline-load strobe.
REQ-014 dly_set  output  1  common strobe transferring pipeline registers into active delay.
REQ-015 done  output  1  one-cycle pulse on completion of an apply command.
REQ-016 err  output  1  one-cycle pulse when a load targets lane >= NUM_LANES.
REQ-017 rd_lane  input  LANE_W  readback lane select.
REQ-018 rd_delay  output  5  active (applied) tap value of rd_lane, registered, 1-cycle latency.
REQ-019 pending  output  NUM_LANES  lanes loaded but not yet applied.

Function
REQ-020 Command accepted on a rising edge with cmd_valid=1 and cmd_ready=1 (cycle T).
REQ-021 States: IDLE, LOAD, WAIT, SET; cmd_ready=1 only in IDLE.
REQ-022 Load, valid lane: IDLE->LOAD; at T+1 dly_data=cmd_delay, dly_ld[cmd_lane]=1 for exactly one cycle, pending[cmd_lane] set, pipe shadow[cmd_lane]=cmd_delay; LOAD->IDLE; next accept no earlier than T+2.
REQ-023 Load, lane >= NUM_LANES: no dly_ld, no shadow or pending change; err=1 at T+1; LOAD->IDLE.
REQ-024 Repeated load to an already-pending lane overwrites its pipe shadow; pending stays set.
REQ-025 dly_data holds its last driven value outside LOAD.
REQ-026 Apply with pending=0: done=1 at T+1, no dly_set, return to IDLE.
REQ-027 Apply with pending!=0: IDLE->WAIT for SETTLE cycles (SETTLE=0 skips WAIT) -> SET; in SET dly_set=1 and done=1 for one cycle, active shadow of every pending lane takes its pipe shadow, pending cleared; SET->IDLE.
REQ-028 With SETTLE=2 an accepted apply yields dly_set at T+3.
REQ-029 dly_ld and dly_set never asserted in the same cycle; at most one dly_ld bit high per cycle.
REQ-030 rd_delay reflects the active shadow only (never the pipe shadow); a lane applied in SET cycle S reads back new value for rd_lane sampled at S+1 onward; rd_lane >= NUM_LANES reads 0.

Reset
REQ-031 On rst: state IDLE, cmd_ready=1 after release, dly_data=0, dly_ld=0, dly_set=0, done=0, err=0, pending=0, rd_delay=DELAY_VALUE, all pipe and active shadows=DELAY_VALUE.
REQ-032 Reset asserted mid-LOAD, WAIT or SET aborts immediately; no strobe emitted after assertion; in-flight command discarded.

Structure
REQ-033 Shared package holds state encoding, tap width constant (5) and SETTLE maximum; used by sequencer and any future multi-bank wrapper.
REQ-034 One natural sub-module: idelay_lane_shadow (per-lane pipe/active register pair with pending bit), instantiated NUM_LANES times.
REQ-035 Single always-block FSM; no combinational path from cmd_* to dly_* outputs.

Verification
REQ-036 Load lane 3 tap 17 at T -> T+1: dly_ld=0x08, dly_data=17, pending=0x08, cmd_ready=0; T+2 cmd_ready=1.
REQ-037 Loads lane0=5, lane7=31, then apply (SETTLE=2) -> dly_set and done at apply T+3, pending=0, rd_delay lane7=31, lane0=5.
REQ-038 Apply with nothing pending -> done at T+1, dly_set never asserted.
REQ-039 NUM_LANES=6, load lane 6 -> err at T+1, dly_ld=0, pending unchanged.
REQ-040 Load lane 2 tap 9, apply, assert rst during WAIT -> dly_set never pulses, pending=0, rd_delay lane2=DELAY_VALUE after reset.
REQ-041 Load lane1 tap 4 then tap 12 before apply -> after apply rd_delay lane1=12, exactly two dly_ld pulses, one dly_set.

Source files
------------

// File: rtl/idelay_load_seq_pkg.sv
// Shared constants and state encoding for the IDELAY load sequencer family.
package idelay_load_seq_pkg;

    localparam int unsigned TAP_W      = 5;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_SET  = 2'd3
    } state_t;

endpackage

// File: rtl/idelay_load_seq_if.sv
// Command handshake between a controller and the IDELAY load sequencer.
interface idelay_load_seq_if
    import idelay_load_seq_pkg::*;
#(
    parameter int unsigned LANE_W = 3
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_apply;
    logic [LANE_W-1:0] cmd_lane;
    logic [TAP_W-1:0]  cmd_delay;

    modport master (
        output cmd_valid,
        output cmd_apply,
        output cmd_lane,
        output cmd_delay,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_apply,
        input  cmd_lane,
        input  cmd_delay,
        output cmd_ready
    );

endinterface

// File: rtl/idelay_load_seq_lane_shadow.sv
// One lane's pipe/active tap register pair with its pending flag.
module idelay_lane_shadow
    import idelay_load_seq_pkg::*;
#(
    parameter int unsigned DELAY_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [TAP_W-1:0] data,
    input  logic             apply,
    output logic [TAP_W-1:0] active,
    output logic             pending
);

    logic [TAP_W-1:0] pipe;

    // Load captures into the pipe copy; apply moves a pending pipe value to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe    <= TAP_W'(DELAY_VALUE);
            active  <= TAP_W'(DELAY_VALUE);
            pending <= 1'b0;
        end else if (ld) begin
            pipe    <= data;
            pending <= 1'b1;
        end else if (apply && pending) begin
            active  <= pipe;
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/idelay_load_seq.sv
// Sequences per-lane IDELAY tap loads and a common settle-then-set apply.
module idelay_load_seq
    import idelay_load_seq_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned LANE_W      = 3,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned DELAY_VALUE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    idelay_load_seq_if.slave     cmd,
    output logic [TAP_W-1:0]     dly_data,
    output logic [NUM_LANES-1:0] dly_ld,
    output logic                 dly_set,
    output logic                 done,
    output logic                 err,
    input  logic [LANE_W-1:0]    rd_lane,
    output logic [TAP_W-1:0]     rd_delay,
    output logic [NUM_LANES-1:0] pending
);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [NUM_LANES-1:0] ld_n;
    logic                 set_n, done_n, err_n, ready_n;
    logic [TAP_W-1:0]     data_n;
    logic                 apply_c;
    logic                 accept_c;
    logic                 lane_ok_c;
    logic [TAP_W-1:0]     active [NUM_LANES];

    assign accept_c  = cmd.cmd_valid && cmd.cmd_ready;
    assign lane_ok_c = (32'(cmd.cmd_lane) < NUM_LANES);

    // State, settle counter and all registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            dly_ld        <= '0;
            dly_set       <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            dly_data      <= '0;
            cmd.cmd_ready <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            dly_ld        <= ld_n;
            dly_set       <= set_n;
            done          <= done_n;
            err           <= err_n;
            dly_data      <= data_n;
            cmd.cmd_ready <= ready_n;
        end
    end

    // Next state plus next values of the registered strobes.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ld_n    = '0;
        set_n   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        data_n  = dly_data;
        apply_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (cmd.cmd_apply) begin
                        if (pending == '0) begin
                            done_n = 1'b1;
                        end else if (SETTLE == 0) begin
                            state_n = ST_SET;
                            set_n   = 1'b1;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_WAIT;
                            cnt_n   = CNT_W'(SETTLE - 1);
                        end
                    end else begin
                        state_n = ST_LOAD;
                        if (lane_ok_c) begin
                            ld_n   = NUM_LANES'(1) << cmd.cmd_lane;
                            data_n = cmd.cmd_delay;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: state_n = ST_IDLE;
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_n = ST_SET;
                    set_n   = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_SET: begin
                state_n = ST_IDLE;
                apply_c = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        ready_n = (state_n == ST_IDLE);
    end

    // Per-lane shadow registers; loads land on the same edge as the ld strobe.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        idelay_lane_shadow #(
            .DELAY_VALUE (DELAY_VALUE)
        ) u_shadow (
            .clk     (clk),
            .rst     (rst),
            .ld      (ld_n[i]),
            .data    (cmd.cmd_delay),
            .apply   (apply_c),
            .active  (active[i]),
            .pending (pending[i])
        );
    end

    // Registered readback of the applied tap value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_delay <= TAP_W'(DELAY_VALUE);
        end else if (32'(rd_lane) < NUM_LANES) begin
            rd_delay <= active[rd_lane];
        end else begin
            rd_delay <= '0;
        end
    end

endmodule

// File: tb/tb_idelay_load_seq.sv
// Randomized bench for idelay_load_seq: an 8-lane/SETTLE=2 and a 6-lane/SETTLE=0 instance.
module tb_idelay_load_seq;

    localparam int unsigned K_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idelay_load_seq_if #(.LANE_W(3)) if0 ();
    idelay_load_seq_if #(.LANE_W(3)) if1 ();

    logic [4:0] data0, data1, rdd0, rdd1;
    logic [7:0] ld0, pend0;
    logic [5:0] ld1, pend1;
    logic       set0, set1, done0, done1, err0, err1;
    logic [2:0] rd_lane;

    idelay_load_seq #(.NUM_LANES(8), .LANE_W(3), .SETTLE(2), .DELAY_VALUE(0)) u_dut0 (
        .clk(clk), .rst(rst), .cmd(if0), .dly_data(data0), .dly_ld(ld0), .dly_set(set0),
        .done(done0), .err(err0), .rd_lane(rd_lane), .rd_delay(rdd0), .pending(pend0)
    );

    idelay_load_seq #(.NUM_LANES(6), .LANE_W(3), .SETTLE(0), .DELAY_VALUE(21)) u_dut1 (
        .clk(clk), .rst(rst), .cmd(if1), .dly_data(data1), .dly_ld(ld1), .dly_set(set1),
        .done(done1), .err(err1), .rd_lane(rd_lane), .rd_delay(rdd1), .pending(pend1)
    );

    logic [7:0] o_ld [2];
    logic [7:0] o_pend [2];
    logic [4:0] o_data [2];
    logic [4:0] o_rd [2];
    logic       o_set [2];
    logic       o_done [2];
    logic       o_err [2];
    logic       o_rdy [2];

    always_comb begin
        o_ld[0] = ld0;         o_ld[1] = {2'b00, ld1};
        o_pend[0] = pend0;     o_pend[1] = {2'b00, pend1};
        o_data[0] = data0;     o_data[1] = data1;
        o_rd[0] = rdd0;        o_rd[1] = rdd1;
        o_set[0] = set0;       o_set[1] = set1;
        o_done[0] = done0;     o_done[1] = done1;
        o_err[0] = err0;       o_err[1] = err1;
        o_rdy[0] = if0.cmd_ready;
        o_rdy[1] = if1.cmd_ready;
    end

    function automatic int nl(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic int st(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [4:0] dv(input int d);
        return (d == 0) ? 5'd0 : 5'd21;
    endfunction

    // Reference model: pipe/active tap arrays, pending set, last tap on the bus.
    logic [4:0] m_pipe [2][8];
    logic [4:0] m_act  [2][8];
    logic [7:0] m_pend [2];
    logic [4:0] m_data [2];

    int n_chk  = 0;
    int n_pass = 0;
    int ld_cnt [2] = '{0, 0};
    int set_cnt [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                m_pipe[d][i] = dv(d);
                m_act[d][i]  = dv(d);
            end
            m_pend[d] = '0;
            m_data[d] = '0;
        end
    endtask

    task automatic set_cmd(input logic v, input logic a, input logic [2:0] lane, input logic [4:0] dly);
        if0.cmd_valid = v; if0.cmd_apply = a; if0.cmd_lane = lane; if0.cmd_delay = dly;
        if1.cmd_valid = v; if1.cmd_apply = a; if1.cmd_lane = lane; if1.cmd_delay = dly;
    endtask

    // Strobe bookkeeping and per-cycle strobe exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (o_ld[d] != '0) ld_cnt[d]++;
                if (o_set[d]) set_cnt[d]++;
                check($sformatf("d%0d_ld_set_excl", d), 32'((o_ld[d] != '0) && o_set[d]), 32'd0);
                check($sformatf("d%0d_ld_onehot0", d), 32'($countones(o_ld[d]) <= 1), 32'd1);
            end
        end
    end

    // Issue one command to both instances and check every cycle until both settle.
    task automatic do_cmd(input logic a, input logic [2:0] lane, input logic [4:0] dly);
        int         kind [2];
        logic [7:0] pend_pre [2];
        logic [4:0] data_pre [2];
        logic [7:0] bit_l;
        int         guard;
        guard = 0;
        while (!(o_rdy[0] && o_rdy[1]) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(o_rdy[0] && o_rdy[1]), 32'd1);
        bit_l = 8'(1) << lane;
        for (int d = 0; d < 2; d++) begin
            pend_pre[d] = m_pend[d];
            data_pre[d] = m_data[d];
            if (!a) kind[d] = (int'(lane) < nl(d)) ? 0 : 1;
            else    kind[d] = (m_pend[d] == '0) ? 2 : 3;
        end
        set_cmd(1'b1, a, lane, dly);
        @(posedge clk);
        for (int k = 1; k <= int'(K_MAX); k++) begin
            @(negedge clk);
            if (k == 1) set_cmd(1'b0, 1'b0, 3'd0, 5'd0);
            for (int d = 0; d < 2; d++) begin
                logic [7:0] e_ld, e_pend;
                logic       e_set, e_done, e_err, e_rdy;
                logic [4:0] e_data;
                e_ld   = (kind[d] == 0 && k == 1) ? bit_l : 8'h00;
                e_err  = (kind[d] == 1 && k == 1);
                e_set  = (kind[d] == 3 && k == st(d) + 1);
                e_done = (kind[d] == 2 && k == 1) || e_set;
                case (kind[d])
                    0, 1:    e_rdy = (k >= 2);
                    2:       e_rdy = 1'b1;
                    default: e_rdy = (k >= st(d) + 2);
                endcase
                if (kind[d] == 0)      e_pend = pend_pre[d] | bit_l;
                else if (kind[d] == 3) e_pend = (k >= st(d) + 2) ? 8'h00 : pend_pre[d];
                else                   e_pend = pend_pre[d];
                e_data = (kind[d] == 0) ? dly : data_pre[d];
                check($sformatf("d%0d_k%0d_ld", d, k),    32'(o_ld[d]),   32'(e_ld));
                check($sformatf("d%0d_k%0d_set", d, k),   32'(o_set[d]),  32'(e_set));
                check($sformatf("d%0d_k%0d_done", d, k),  32'(o_done[d]), 32'(e_done));
                check($sformatf("d%0d_k%0d_err", d, k),   32'(o_err[d]),  32'(e_err));
                check($sformatf("d%0d_k%0d_ready", d, k), 32'(o_rdy[d]), 32'(e_rdy));
                check($sformatf("d%0d_k%0d_pend", d, k),  32'(o_pend[d]), 32'(e_pend));
                check($sformatf("d%0d_k%0d_data", d, k),  32'(o_data[d]), 32'(e_data));
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (kind[d] == 0) begin
                m_pipe[d][lane] = dly;
                m_pend[d]       = m_pend[d] | bit_l;
                m_data[d]       = dly;
            end else if (kind[d] == 3) begin
                for (int i = 0; i < 8; i++)
                    if (m_pend[d][i]) m_act[d][i] = m_pipe[d][i];
                m_pend[d] = '0;
            end
        end
    endtask

    task automatic check_rd(input logic [2:0] lane);
        rd_lane = lane;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_rd_lane%0d", d, lane), 32'(o_rd[d]),
                  (int'(lane) < nl(d)) ? 32'(m_act[d][lane]) : 32'd0);
    endtask

    task automatic check_idle_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_ready", tag, d), 32'(o_rdy[d]),  32'd1);
            check($sformatf("%s_d%0d_ld", tag, d),    32'(o_ld[d]),   32'd0);
            check($sformatf("%s_d%0d_set", tag, d),   32'(o_set[d]),  32'd0);
            check($sformatf("%s_d%0d_done", tag, d),  32'(o_done[d]), 32'd0);
            check($sformatf("%s_d%0d_err", tag, d),   32'(o_err[d]),  32'd0);
            check($sformatf("%s_d%0d_pend", tag, d),  32'(o_pend[d]), 32'd0);
            check($sformatf("%s_d%0d_data", tag, d),  32'(o_data[d]), 32'd0);
            check($sformatf("%s_d%0d_rd", tag, d),    32'(o_rd[d]),   32'(dv(d)));
        end
    endtask

    initial begin
        int ld_s [2];
        int set_s [2];
        int s0;
        model_reset();
        set_cmd(1'b0, 1'b0, 3'd0, 5'd0);
        rd_lane = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_state("reset");

        // Directed scenarios
        do_cmd(1'b0, 3'd3, 5'd17);
        do_cmd(1'b1, 3'd0, 5'd0);
        check_rd(3'd3);
        do_cmd(1'b0, 3'd0, 5'd5);
        do_cmd(1'b0, 3'd7, 5'd31);
        do_cmd(1'b1, 3'd0, 5'd0);
        check_rd(3'd7);
        check_rd(3'd0);
        do_cmd(1'b1, 3'd0, 5'd0);
        do_cmd(1'b0, 3'd6, 5'd9);
        check_rd(3'd6);
        do_cmd(1'b1, 3'd0, 5'd0);
        check_rd(3'd6);

        // Overwrite of a pending lane before apply
        for (int d = 0; d < 2; d++) begin ld_s[d] = ld_cnt[d]; set_s[d] = set_cnt[d]; end
        do_cmd(1'b0, 3'd1, 5'd4);
        do_cmd(1'b0, 3'd1, 5'd12);
        do_cmd(1'b1, 3'd0, 5'd0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_ld_pulses", d),  32'(ld_cnt[d] - ld_s[d]),   32'd2);
            check($sformatf("d%0d_set_pulses", d), 32'(set_cnt[d] - set_s[d]), 32'd1);
        end
        check_rd(3'd1);
        check($sformatf("rd1_eq_12"), 32'(o_rd[0]), 32'd12);

        // Random command stream
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) check_rd(3'($urandom_range(0, 7)));
        end

        // Reset during the settle wait discards the apply
        do_cmd(1'b0, 3'd2, 5'd9);
        s0 = set_cnt[0];
        set_cmd(1'b1, 1'b1, 3'd0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        set_cmd(1'b0, 1'b0, 3'd0, 5'd0);
        rst = 1'b1;
        #1;
        check("rst_set_low", 32'(o_set[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_no_set_pulse", 32'(set_cnt[0] - s0), 32'd0);
        rd_lane = 3'd0;
        @(negedge clk);
        check_idle_state("post_rst");
        check_rd(3'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
